// File: rtl/sample_recorder_snare.sv
// Records a stream of audio samples into the snare sample RAM at addresses 0..MAXCOUNT.
// Optional macro TRIG_THRESH_EN: go arms a |sample| >= THRESH trigger before recording starts.
module sample_recorder_snare #(
  parameter logic [14:0]   MAXCOUNT = 15'd16481,
  parameter int            DW       = 16,
  parameter logic [DW-1:0] THRESH   = 16'd2048
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          go,
  input  logic          abort,
  input  logic          sample_valid,
  input  logic [DW-1:0] sample,
  output logic          wr_en,
  output logic [14:0]   wr_addr,
  output logic [DW-1:0] wr_data,
  output logic [14:0]   length,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ARM    = 2'd1,
    S_RECORD = 2'd2,
    S_DONE   = 2'd3
  } state_t;

`ifdef TRIG_THRESH_EN
  localparam state_t START_STATE = S_ARM;
`else
  localparam state_t START_STATE = S_RECORD;
`endif

  state_t        state_q, state_d;
  logic [14:0]   length_q, length_d;
  logic          wr_en_q, wr_en_d;
  logic [14:0]   wr_addr_q, wr_addr_d;
  logic [DW-1:0] wr_data_q, wr_data_d;

  logic [DW:0]   magnitude;
  logic          above_thresh;
  logic          accept;

  // One extra bit so |-32768| is representable and compares as above threshold.
  always_comb begin
    if (sample[DW-1]) magnitude = {1'b0, ~sample} + {{DW{1'b0}}, 1'b1};
    else              magnitude = {1'b0, sample};
    above_thresh = (magnitude >= {1'b0, THRESH});
  end

  always_comb begin
    state_d   = state_q;
    length_d  = length_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    accept    = 1'b0;

    if (go) begin
      state_d  = START_STATE;
      length_d = '0;
    end else begin
      case (state_q)
        S_IDLE: ;
        S_ARM: begin
          if (abort) begin
            state_d = S_DONE;
          end else if (sample_valid && above_thresh) begin
            accept  = 1'b1;
            state_d = S_RECORD;
          end
        end
        S_RECORD: begin
          // length_q doubles as the write pointer; past MAXCOUNT the last write is on the bus.
          if (abort) begin
            state_d = S_DONE;
          end else if (length_q > MAXCOUNT) begin
            state_d = S_DONE;
          end else if (sample_valid) begin
            accept = 1'b1;
          end
        end
        S_DONE: ;
        default: state_d = S_IDLE;
      endcase
    end

    if (accept) begin
      wr_en_d   = 1'b1;
      wr_addr_d = length_q;
      wr_data_d = sample;
      length_d  = length_q + 15'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      length_q  <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      length_q  <= length_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign length  = length_q;
  assign busy    = (state_q == S_ARM) || (state_q == S_RECORD);
  assign done    = (state_q == S_DONE);

endmodule

// File: tb/tb_sample_recorder_snare.sv
// Directed bench for sample_recorder_snare: expected RAM writes are queued as samples are
// driven and popped by a monitor when wr_en appears; status outputs checked inline.
module tb_sample_recorder_snare;

  logic        clk = 1'b0;
  logic        reset;
  logic        go;
  logic        abort;
  logic        sample_valid;
  logic [15:0] sample;
  logic        wr_en;
  logic [14:0] wr_addr;
  logic [15:0] wr_data;
  logic [14:0] length;
  logic        busy;
  logic        done;

  typedef struct {
    logic [14:0] addr;
    logic [15:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  sample_recorder_snare dut (
    .clk          (clk),
    .reset        (reset),
    .go           (go),
    .abort        (abort),
    .sample_valid (sample_valid),
    .sample       (sample),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .length       (length),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: every write must match the oldest queued expectation.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {17'd0, wr_addr}, 32'h7fff_ffff);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", {17'd0, wr_addr}, {17'd0, e.addr});
        check("wr_data", {16'd0, wr_data}, {16'd0, e.data});
        check("busy_during_write", {31'd0, busy}, 32'd1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_go();
    go = 1'b1;
    tick();
    go = 1'b0;
  endtask

  task automatic send(input logic [15:0] val, input bit expect_wr, input logic [14:0] a);
    wr_t e;
    sample_valid = 1'b1;
    sample       = val;
    if (expect_wr) begin
      e.addr = a;
      e.data = val;
      exp_q.push_back(e);
    end
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 10 && exp_q.size() != 0; k++) tick();
    check(tag, exp_q.size(), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    tick();
  endtask

  initial begin
    reset = 1'b1; go = 1'b0; abort = 1'b0; sample_valid = 1'b0; sample = '0;
    #1;
    check("rst_wr_en",   {31'd0, wr_en},   32'd0);
    check("rst_length",  {17'd0, length},  32'd0);
    check("rst_busy",    {31'd0, busy},    32'd0);
    check("rst_done",    {31'd0, done},    32'd0);
    tick();
    reset = 1'b0;
    tick();

    // Full-length recording with back-to-back samples, data = address.
    pulse_go();
    check("go_busy", {31'd0, busy}, 32'd1);
`ifdef TRIG_THRESH_EN
    send(16'h8000, 1'b1, 15'd0);
    for (int i = 1; i < 16482; i++) send(i[15:0], 1'b1, i[14:0]);
`else
    for (int i = 0; i < 16482; i++) send(i[15:0], 1'b1, i[14:0]);
`endif
    tick();
    check("full_done",   {31'd0, done},   32'd1);
    check("full_busy",   {31'd0, busy},   32'd0);
    check("full_length", {17'd0, length}, 32'd16482);
    check("full_last_addr", {17'd0, wr_addr}, 32'd16481);
    send(16'h1234, 1'b0, 15'd0);
    tick();
    drain("full_drain");

    // Abort after 10 samples; the sample_valid in the abort cycle is dropped.
    pulse_go();
`ifdef TRIG_THRESH_EN
    send(16'd3000, 1'b1, 15'd0);
    for (int i = 1; i < 10; i++) send(16'd100 + i[15:0], 1'b1, i[14:0]);
`else
    for (int i = 0; i < 10; i++) send(16'd100 + i[15:0], 1'b1, i[14:0]);
`endif
    abort = 1'b1;
    send(16'hbeef, 1'b0, 15'd0);
    abort = 1'b0;
    tick();
    check("abort_done",   {31'd0, done},    32'd1);
    check("abort_length", {17'd0, length},  32'd10);
    check("abort_addr",   {17'd0, wr_addr}, 32'd9);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_in_done", {31'd0, done}, 32'd1);
    drain("abort_drain");

    // Restart mid-recording at length 500: go beats a coincident sample_valid.
    pulse_go();
`ifdef TRIG_THRESH_EN
    send(16'hf000, 1'b1, 15'd0);
    for (int i = 1; i < 500; i++) send(16'h4000 ^ i[15:0], 1'b1, i[14:0]);
`else
    for (int i = 0; i < 500; i++) send(16'h4000 ^ i[15:0], 1'b1, i[14:0]);
`endif
    tick();
    check("pre_restart_length", {17'd0, length}, 32'd500);
    go = 1'b1;
    send(16'h5555, 1'b0, 15'd0);
    go = 1'b0;
    check("restart_length0", {17'd0, length}, 32'd0);
    send(16'h7abc, 1'b1, 15'd0);
    check("restart_length1", {17'd0, length}, 32'd1);
    drain("restart_drain");

    // Reset mid-stream: outputs clear without waiting for a clock edge.
    send(16'h2222, 1'b1, 15'd1);
    reset = 1'b1;
    #1;
    check("midrst_wr_en",   {31'd0, wr_en},   32'd0);
    check("midrst_wr_addr", {17'd0, wr_addr}, 32'd0);
    check("midrst_wr_data", {16'd0, wr_data}, 32'd0);
    check("midrst_length",  {17'd0, length},  32'd0);
    check("midrst_busy",    {31'd0, busy},    32'd0);
    exp_q.delete();
    tick();
    reset = 1'b0;
    send(16'h3333, 1'b0, 15'd0);
    tick();
    check("postrst_idle_busy", {31'd0, busy}, 32'd0);
    check("postrst_wr_en",     {31'd0, wr_en}, 32'd0);

    // go and sample_valid in the same IDLE cycle: no write; next sample goes to addr 0.
    go = 1'b1;
    send(16'h6000, 1'b0, 15'd0);
    go = 1'b0;
    send(16'h6001, 1'b1, 15'd0);
    send(16'h6002, 1'b1, 15'd1);
    drain("go_valid_drain");
    check("go_valid_length", {17'd0, length}, 32'd2);

    // Threshold trigger pattern.
    do_reset();
    pulse_go();
`ifdef TRIG_THRESH_EN
    send(16'd100,   1'b0, 15'd0);
    send(-16'sd2000, 1'b0, 15'd0);
    check("arm_no_len", {17'd0, length}, 32'd0);
    send(-16'sd2048, 1'b1, 15'd0);
    send(16'd5,     1'b1, 15'd1);
    tick();
    check("trig_length", {17'd0, length}, 32'd2);
`else
    send(16'd100,    1'b1, 15'd0);
    send(-16'sd2000, 1'b1, 15'd1);
    send(-16'sd2048, 1'b1, 15'd2);
    send(16'd5,      1'b1, 15'd3);
    tick();
    check("trig_length", {17'd0, length}, 32'd4);
`endif
    drain("trig_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
